lpattern_gen: RTL and testbench

- Pattern generator: the playback counterpart of the FIFO logic analyzer.
- The host loads 32-bit words over the com link into a single-address write port and buffers them in an internal RAM FIFO.
- On RUN, the block replays the words onto a 32-bit output bus at a programmable rate, once or looped.
- It is used to stimulate trigger logic from known patterns. The com link and playback share one clock.

---
 rtl/lpattern_gen.sv | 176 +++++++++++++++++
 tb/tb_lpattern_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpattern_gen.sv
// lpattern_gen: FIFO-buffered pattern generator replaying host-loaded 32-bit words at a programmable rate
// Ports: rdclk/rst (async, active-low); com link DataIn/DataOut/Address/Read/Write/ack;
//        playback PatOut/PatValid/Busy; ExtTrig exists only when LPG_EXT_TRIG_EN is defined (adds ARM, ctrl bit3).
module lpattern_gen #(
  parameter logic [7:0] MYAD = 8'hFC,
  parameter logic [7:0] ContAD = 8'hFB,
  parameter logic [7:0] StatAD = 8'hFA,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        rdclk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  output logic        ack,
`ifdef LPG_EXT_TRIG_EN
  input  logic        ExtTrig,
`endif
  output logic [31:0] PatOut,
  output logic        PatValid,
  output logic        Busy
);
  localparam int AW = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE_C = 1;
  localparam logic [AW-1:0] ONE_P = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, off_q, off_d, pidx;
  logic [AW:0] count_q, count_d;
  logic [7:0] div_q, div_d, divcnt_q, divcnt_d;
  logic run_q, run_d, loop_q, loop_d, arm_q, arm_d, ovf_q, ovf_d, first_q, first_d;
  logic push_prev_q, ctrl_prev_q, acc_prev_q, ack_q, ack_d, pat_valid_q, pat_valid_d;
  logic [31:0] pat_out_q, pat_out_d;
  logic [31:0] mem_q [DEPTH];
  logic push_req, ctrl_req, acc, push_edge, ctrl_edge, clr, full, empty;
  logic push_ok, tick, pop, last_off, trig_ok, waiting;
  logic [31:0] ctrl_rd, stat_rd;
  assign push_req = Write && Address == MYAD;
  assign ctrl_req = Write && Address == ContAD;
  assign acc = (Read || Write) && (Address == MYAD || Address == ContAD || Address == StatAD);
  assign push_edge = push_req && !push_prev_q;
  assign ctrl_edge = ctrl_req && !ctrl_prev_q;
  assign clr = ctrl_edge && DataIn[1];
  assign full = count_q[AW];
  assign empty = count_q == '0;
  assign push_ok = push_edge && !full && !(state_q != IDLE && loop_q);
  // the first word after leaving IDLE is emitted at once, so start latency does not depend on DIV
  assign tick = state_q == PLAY && run_q && (first_q || divcnt_q == div_q);
  assign pidx = rptr_q + off_q;
  assign last_off = ({1'b0, off_q} + ONE_C) == count_q;
  assign ack_d = acc && !acc_prev_q;
`ifdef LPG_EXT_TRIG_EN
  logic trig_q, trig_prev_q;
  always_ff @(posedge rdclk or negedge rst)
    if (!rst) begin
      trig_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_q <= ExtTrig;
      trig_prev_q <= trig_q;
    end
  assign trig_ok = !arm_q || (trig_q && !trig_prev_q);
`else
  assign trig_ok = 1'b1;
`endif
  assign waiting = arm_q && run_q && state_q == IDLE;
  assign ctrl_rd = {16'h0, div_q, 4'h0, arm_q, loop_q, 1'b0, run_q};
  assign stat_rd = {state_q, ovf_q, empty, full, waiting, {(25 - AW){1'b0}}, count_q};
  assign DataOut = !Read ? '0 : Address == ContAD ? ctrl_rd : Address == StatAD ? stat_rd : '0;
  assign ack = ack_q;
  assign PatOut = pat_out_q;
  assign PatValid = pat_valid_q;
  assign Busy = state_q == PLAY;
  always_comb begin
    state_d = state_q;
    wptr_d = push_ok ? wptr_q + ONE_P : wptr_q;
    rptr_d = rptr_q;
    off_d = off_q;
    divcnt_d = divcnt_q;
    first_d = first_q;
    pop = 1'b0;
    pat_valid_d = 1'b0;
    pat_out_d = pat_out_q;
    run_d = ctrl_edge ? DataIn[0] : run_q;
    loop_d = ctrl_edge ? DataIn[2] : loop_q;
    div_d = ctrl_edge ? DataIn[15:8] : div_q;
`ifdef LPG_EXT_TRIG_EN
    arm_d = ctrl_edge ? DataIn[3] : arm_q;
`else
    arm_d = 1'b0;
`endif
    ovf_d = ovf_q || (push_edge && !push_ok);
    case (state_q)
      IDLE:
        if (run_q && !empty && trig_ok) begin
          state_d = PLAY;
          divcnt_d = '0;
          off_d = '0;
          first_d = 1'b1;
        end
      PLAY:
        if (!run_q) state_d = IDLE;
        else if (tick) begin
          pat_valid_d = 1'b1;
          pat_out_d = mem_q[pidx];
          divcnt_d = '0;
          first_d = 1'b0;
          if (loop_q) off_d = last_off ? '0 : off_q + ONE_P;
          else begin
            pop = 1'b1;
            rptr_d = rptr_q + ONE_P;
            if (count_q == ONE_C && !push_ok) state_d = DONE;
          end
        end else divcnt_d = divcnt_q + 8'd1;
      DONE: if (!run_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    count_d = count_q + (push_ok ? ONE_C : '0) - (pop ? ONE_C : '0);
    if (clr) begin
      state_d = IDLE;
      wptr_d = '0;
      rptr_d = '0;
      off_d = '0;
      count_d = '0;
      divcnt_d = '0;
      ovf_d = 1'b0;
      run_d = 1'b0;
      pat_valid_d = 1'b0;
    end
  end
  always_ff @(posedge rdclk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      off_q <= '0;
      count_q <= '0;
      div_q <= '0;
      divcnt_q <= '0;
      run_q <= 1'b0;
      loop_q <= 1'b0;
      arm_q <= 1'b0;
      ovf_q <= 1'b0;
      first_q <= 1'b0;
      push_prev_q <= 1'b0;
      ctrl_prev_q <= 1'b0;
      acc_prev_q <= 1'b0;
      ack_q <= 1'b0;
      pat_valid_q <= 1'b0;
      pat_out_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      off_q <= off_d;
      count_q <= count_d;
      div_q <= div_d;
      divcnt_q <= divcnt_d;
      run_q <= run_d;
      loop_q <= loop_d;
      arm_q <= arm_d;
      ovf_q <= ovf_d;
      first_q <= first_d;
      push_prev_q <= push_req;
      ctrl_prev_q <= ctrl_req;
      acc_prev_q <= acc;
      ack_q <= ack_d;
      pat_valid_q <= pat_valid_d;
      pat_out_q <= pat_out_d;
    end
  always_ff @(posedge rdclk)
    if (push_ok) mem_q[wptr_q] <= DataIn;
endmodule

// File: tb/tb_lpattern_gen.sv
// tb_lpattern_gen: randomized and directed check of lpattern_gen against a schedule-based playback model
module tb_lpattern_gen;
  localparam logic [7:0] MYAD = 8'hFC;
  localparam logic [7:0] ContAD = 8'hFB;
  localparam logic [7:0] StatAD = 8'hFA;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic [7:0] Address = '0;
  logic Read = 1'b0;
  logic Write = 1'b0;
  logic ack;
  logic [31:0] PatOut;
  logic PatValid;
  logic Busy;
  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int wr_e = 0;
  int run_e = 0;
  int stop_e = 0;
  int sn = 1;
  int sd = 0;
  bit sl = 0;
  bit sact = 0;
  logic [31:0] sw[$];
  logic [31:0] exp_p = '0;
  bit acc_prev = 0;
  bit exp_ack = 0;

  lpattern_gen dut (
    .rdclk(clk), .rst(rst), .DataIn(DataIn), .DataOut(DataOut), .Address(Address),
    .Read(Read), .Write(Write), .ack(ack), .PatOut(PatOut), .PatValid(PatValid), .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s at edge %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  // ack: one pulse per rising edge of any access to the three addresses
  always @(posedge clk or negedge rst) begin
    bit a;
    if (!rst) begin
      acc_prev = 0;
      exp_ack = 0;
    end else begin
      a = (Read || Write) && (Address == MYAD || Address == ContAD || Address == StatAD);
      exp_ack = a && !acc_prev;
      acc_prev = a;
    end
  end

  // playback schedule: word k appears 2 edges after the RUN edge plus k*(DIV+1) edges
  always @(negedge clk) begin
    int k, per;
    bit ev, eb;
    ev = 0;
    eb = 0;
    if (!rst) begin
      sact = 0;
      exp_p = '0;
    end else if (sact) begin
      per = sd + 1;
      k = cyc - run_e - 2;
      eb = cyc >= run_e + 1 && (sl ? cyc <= stop_e : cyc <= run_e + 1 + (sn - 1) * per);
      if (k >= 0 && k % per == 0 && (sl ? cyc <= stop_e : k / per < sn)) begin
        ev = 1;
        exp_p = sw[(k / per) % sn];
      end
    end
    chk("pat_valid", {31'h0, PatValid}, {31'h0, ev});
    chk("pat_out", PatOut, exp_p);
    chk("busy", {31'h0, Busy}, {31'h0, eb});
    chk("ack", {31'h0, ack}, {31'h0, exp_ack});
    if (!Read) chk("dataout_idle", DataOut, 32'h0);
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    Address = a;
    DataIn = d;
    Write = 1'b1;
    wr_e = cyc + 1;
    @(posedge clk); #1;
    Write = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] want, input string nm);
    @(posedge clk); #1;
    Address = a;
    Read = 1'b1;
    @(negedge clk);
    chk(nm, DataOut, want);
    @(posedge clk); #1;
    Read = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    sw.push_back(d);
    wr(MYAD, d);
  endtask

  task automatic start(input int n, input int d, input bit l);
    sn = n;
    sd = d;
    sl = l;
    stop_e = 1 << 30;
    wr(ContAD, {16'h0, 8'(d), 5'h0, l, 2'b01});
    run_e = wr_e;
    sact = 1;
  endtask

  task automatic fresh();
    sact = 0;
    sw.delete();
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    // 1: reset state
    rd_chk(StatAD, 32'h1000_0000, "reset_status");
    chk("reset_pat_out", PatOut, 32'h0);
    rd_chk(ContAD, 32'h0, "reset_ctrl");
    rd_chk(MYAD, 32'h0, "myad_read");
    // 2: three words at DIV=0
    fresh();
    push(32'hA1); push(32'hA2); push(32'hA3);
    start(3, 0, 0);
    repeat (3) @(negedge clk);
    chk("t2_w0", {PatValid, PatOut[30:0]}, {1'b1, 31'hA1});
    @(negedge clk) chk("t2_w1", {PatValid, PatOut[30:0]}, {1'b1, 31'hA2});
    @(negedge clk) chk("t2_w2", {PatValid, PatOut[30:0]}, {1'b1, 31'hA3});
    @(negedge clk) chk("t2_after", {31'h0, PatValid}, 32'h0);
    rd_chk(StatAD, 32'h9000_0000, "t2_done_status");
    wr(ContAD, 32'h0);
    rd_chk(StatAD, 32'h1000_0000, "t2_idle_status");
    // 3: four words at DIV=3
    fresh();
    for (int i = 0; i < 4; i++) push(32'hB0 + i);
    start(4, 3, 0);
    repeat (20) @(posedge clk);
    rd_chk(ContAD, 32'h0000_0301, "t3_ctrl");
    rd_chk(StatAD, 32'h9000_0000, "t3_done_status");
    wr(ContAD, 32'h0);
    // 4: loop mode, push during play dropped
    fresh();
    push(32'h11); push(32'h22);
    start(2, 0, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_loop", PatOut, (i % 2) ? 32'h22 : 32'h11);
    end
    wr(MYAD, 32'h33);
    repeat (8) @(posedge clk);
    rd_chk(StatAD, 32'h6000_0002, "t4_play_status");
    wr(ContAD, 32'h4);
    stop_e = wr_e;
    repeat (4) @(posedge clk);
    rd_chk(StatAD, 32'h2000_0002, "t4_stopped_status");
    wr(ContAD, 32'h2);
    rd_chk(StatAD, 32'h1000_0000, "t4_clr_status");
    // 5: overfill, 257th word never played
    fresh();
    for (int i = 0; i < 257; i++) begin
      if (i < 256) push(32'h1000 + i);
      else wr(MYAD, 32'hDEAD);
    end
    rd_chk(StatAD, 32'h2800_0100, "t5_full_status");
    start(256, 0, 0);
    repeat (262) @(posedge clk);
    rd_chk(StatAD, 32'hB000_0000, "t5_done_status");
    wr(ContAD, 32'h2);
    rd_chk(StatAD, 32'h1000_0000, "t5_clr_status");
    rd_chk(ContAD, 32'h0, "t5_clr_ctrl");
    // randomized runs
    for (int r = 0; r < 8; r++) begin
      int n, d;
      bit l;
      n = $urandom_range(1, 12);
      d = $urandom_range(0, 4);
      l = 1'($urandom_range(0, 1));
      fresh();
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = $urandom;
        push(w);
      end
      start(n, d, l);
      if (l) begin
        repeat ($urandom_range(10, 40)) @(posedge clk);
        wr(ContAD, {16'h0, 8'(d), 8'h04});
        stop_e = wr_e;
        repeat (4) @(posedge clk);
        wr(ContAD, 32'h2);
      end else begin
        repeat (n * (d + 1) + 4) @(posedge clk);
        rd_chk(StatAD, 32'h9000_0000, "rand_done_status");
        wr(ContAD, 32'h0);
      end
    end
    // 6: held write is one push; reset mid-play
    fresh();
    @(posedge clk); #1;
    Address = MYAD;
    DataIn = 32'h5A;
    Write = 1'b1;
    sw.push_back(32'h5A);
    repeat (5) @(posedge clk);
    #1 Write = 1'b0;
    rd_chk(StatAD, 32'h0000_0001, "t6_one_push");
    push(32'h5B); push(32'h5C);
    start(3, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sact = 0;
    @(negedge clk);
    chk("t6_rst_valid", {31'h0, PatValid}, 32'h0);
    chk("t6_rst_busy", {31'h0, Busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rd_chk(StatAD, 32'h1000_0000, "t6_rst_status");
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
